// File: rtl/wb_traffic_master.sv
// wb_traffic_master: Wishbone classic-cycle initiator issuing LFSR-driven traffic.
// Optional WB_TRAFFIC_MASTER_TIMEOUT_EN: abort a request after `timeout` cycles without ack.
module wb_traffic_master #(
    parameter int unsigned n_trans  = 16,
    parameter logic [31:0] seed     = 32'h0000_0001,
    parameter logic [7:0]  gap_mask = 8'h03,
    parameter int unsigned timeout  = 64
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start,
    output logic [31:0] dat_w,
    input  logic [31:0] dat_r,
    output logic [29:0] adr,
    output logic        we,
    output logic [3:0]  sel,
    output logic        cyc,
    output logic        stb,
    input  logic        ack,
    output logic        busy,
    output logic        done,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
    output logic [31:0] rd_sig,
    output logic        timeout_err
);

    localparam logic [31:0] TAPS    = 32'h8020_0003;
    localparam logic [16:0] N_TOTAL = 17'(n_trans);

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        REQ,
        DONE
    } state_t;

    state_t      state;
    logic [31:0] lfsr;
    logic [8:0]  gap_cnt;

    logic [31:0] lfsr_nxt;
    logic [8:0]  gap_load;
    logic [3:0]  sel_nxt;
    logic [16:0] total_nxt;
    logic        last_xfer;

    // Galois step, right shift; feedback applied when the bit shifted out is 1
    always_comb begin
        lfsr_nxt = lfsr >> 1;
        if (lfsr[0]) begin
            lfsr_nxt = lfsr_nxt ^ TAPS;
        end
    end

    // Idle length is always at least one cycle so back-to-back acks stay unambiguous
    assign gap_load  = {1'b0, lfsr[23:16] & gap_mask} + 9'd1;
    assign sel_nxt   = (lfsr[27:24] == 4'h0) ? 4'hF : lfsr[27:24];
    assign total_nxt = {1'b0, rd_count} + {1'b0, wr_count} + 17'd1;
    assign last_xfer = (total_nxt == N_TOTAL);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

`ifdef WB_TRAFFIC_MASTER_TIMEOUT_EN
    localparam int WW = (timeout < 2) ? 1 : $clog2(timeout);
    localparam logic [WW-1:0] WAIT_LAST = WW'(timeout - 1);

    logic [WW-1:0] wait_cnt;
    logic          timeout_q;

    assign timeout_err = timeout_q;
`else
    logic unused_timeout;

    assign unused_timeout = ^timeout;
    assign timeout_err    = 1'b0;
`endif

    // Run control, bus request generation and per-run statistics
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= IDLE;
            lfsr     <= seed;
            gap_cnt  <= '0;
            adr      <= '0;
            dat_w    <= '0;
            we       <= 1'b0;
            sel      <= 4'h0;
            cyc      <= 1'b0;
            stb      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_count <= '0;
            wr_count <= '0;
            rd_sig   <= '0;
`ifdef WB_TRAFFIC_MASTER_TIMEOUT_EN
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        rd_count <= '0;
                        wr_count <= '0;
                        rd_sig   <= '0;
                        done     <= 1'b0;
                        busy     <= 1'b1;
                        gap_cnt  <= gap_load;
                        state    <= GAP;
`ifdef WB_TRAFFIC_MASTER_TIMEOUT_EN
                        timeout_q <= 1'b0;
`endif
                    end
                end
                GAP: begin
                    if (gap_cnt == 9'd1) begin
                        adr   <= lfsr[29:0];
                        we    <= lfsr[31];
                        sel   <= sel_nxt;
                        dat_w <= {lfsr[15:0], lfsr[31:16]};
                        cyc   <= 1'b1;
                        stb   <= 1'b1;
                        lfsr  <= lfsr_nxt;
                        state <= REQ;
`ifdef WB_TRAFFIC_MASTER_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end else begin
                        gap_cnt <= gap_cnt - 9'd1;
                    end
                end
                REQ: begin
                    if (ack) begin
                        cyc <= 1'b0;
                        stb <= 1'b0;
                        if (we) begin
                            wr_count <= sat_inc(wr_count);
                        end else begin
                            rd_count <= sat_inc(rd_count);
                            rd_sig   <= rd_sig ^ dat_r;
                        end
                        if (last_xfer) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            gap_cnt <= gap_load;
                            state   <= GAP;
                        end
                    end
`ifdef WB_TRAFFIC_MASTER_TIMEOUT_EN
                    else if (wait_cnt == WAIT_LAST) begin
                        cyc       <= 1'b0;
                        stb       <= 1'b0;
                        timeout_q <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/wb_traffic_master.md
# wb_traffic_master

Synthesizable Wishbone classic-cycle initiator that drives pseudo-random read/write traffic into the interconnect for stress and regression benches. It is the master-side counterpart of the randomized-ack slave models and sits on a master port of the Wishbone intercon. Transactions come from a 32-bit LFSR. The block counts completed reads and writes, folds read data into an XOR signature, and signals completion after a programmed number of transfers.

## Interface
- `n_trans`, default 16: transactions per run, 1..65535.
- `seed`, default 32'h00000001: LFSR reset value; must be non-zero.
- `gap_mask`, default 8'h03: mask on `L[23:16]` for the inter-transaction idle length.
- `timeout`, default 64: cycles to wait for `ack` before aborting (see Configuration).
- `sys_clk` in 1: clock; all logic on rising edge.
- `sys_rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request to begin a run; ignored while `busy`.
- `dat_w` out 32: write data.
- `dat_r` in 32: read data.
- `adr` out 30: word address.
- `we` out 1: write enable.
- `sel` out 4: byte selects.
- `cyc` out 1: bus cycle.
- `stb` out 1: strobe.
- `ack` in 1: slave acknowledge.
- `busy` out 1: run in progress.
- `done` out 1: run finished; held until next `start` or reset.
- `rd_count` out 16: completed reads this run.
- `wr_count` out 16: completed writes this run.
- `rd_sig` out 32: XOR of all read data acked this run.
- `timeout_err` out 1: sticky abort flag.

## Operation
- States are IDLE, GAP, REQ and DONE.
- All outputs are registered.
- Reset values: `cyc`, `stb`, `we`, `busy`, `done` and `timeout_err` are 0; `adr`, `dat_w`, counts and `rd_sig` are 0; `sel` is 0; LFSR is loaded with `seed`; state is IDLE.
- LFSR: 32-bit Galois, right shift, taps 32'h80200003. Next value is `L>>1`, XORed with the taps when `L[0]` is 1. It advances exactly once per REQ entry. It is never reseeded except by reset.
- IDLE/DONE + `start`:
  - clear `rd_count`, `wr_count`, `rd_sig`, `timeout_err` and `done`;
  - set `busy`;
  - enter GAP with gap counter G = 1 + (`L[23:16]` & `gap_mask`).
- GAP:
  - `cyc` and `stb` are 0;
  - decrement G;
  - when G reaches 0, enter REQ.
- REQ entry latches from current L:
  - `adr` = `L[29:0]`;
  - `we` = `L[31]`;
  - `sel` = `L[27:24]`, or 4'hF if that is zero;
  - `dat_w` = {`L[15:0]`, `L[31:16]`};
  - assert `cyc` and `stb`; LFSR advances.
- REQ holds all bus outputs stable until `ack` is sampled high. On that edge:
  - deassert `cyc` and `stb`;
  - increment `wr_count` or `rd_count`;
  - for reads, `rd_sig` ^= `dat_r`;
  - if total completed equals `n_trans`, go to DONE; otherwise go to GAP with G from the new L.
- `ack` outside REQ is ignored.
- DONE: `busy`=0 and `done`=1. A `start` here begins a new run from the current LFSR state.
- Counters saturate at 16'hFFFF.

## Timing
- `start` sampled at edge t: `busy`=1 after t; `cyc`/`stb` rise after edge t+G.
- Minimum request duration is 1 cycle (`ack` on the first REQ cycle).
- `cyc`/`stb` fall at the edge that samples `ack`.
- There is always at least one idle bus cycle between requests. This makes single-cycle `ack` pulses from slaves that clear `ack` on the following cycle unambiguous.
- `done` rises at the same edge the final `ack` is sampled; `busy` falls at that edge.
- Reset mid-REQ: `cyc`/`stb` are 0 after the reset edge and no counter update occurs, even if `ack` is high on that edge.
- Simultaneous `start` and final `ack`: `start` is ignored because `busy` is still high.

## Configuration
- `WB_TRAFFIC_MASTER_TIMEOUT_EN` defined:
  - a wait counter clears on REQ entry and increments each REQ cycle without `ack`;
  - when it reaches `timeout`, drop `cyc`/`stb`, set `timeout_err`=1, and go to DONE (`done`=1);
  - the aborted transfer is not counted.
- Undefined: REQ waits indefinitely; `timeout_err` is constant 0; no wait counter is built.

## Test plan
- Reset, `seed`=1, `start`, slave acks on the first cycle:
  - first request is read, `adr`=30'h1, `sel`=4'hF, 1 gap cycle;
  - second request is write, `adr`=30'h00200003, `dat_w`=32'h00038020, `sel`=4'hF.
- `n_trans`=16 with a random-ack slave (1-in-3 probability):
  - `done`=1 and `rd_count`+`wr_count`=16;
  - `rd_sig` equals the XOR of every returned read word;
  - `cyc`/`stb` never change while REQ waits.
- `start` pulsed every cycle during a run: no restart; counts are unaffected.
- `sys_rst` asserted while `cyc`=1 and `ack`=1 on the same edge: all outputs return to reset values and the counts stay 0.
- Macro defined, `timeout`=8, slave never acks: `cyc` drops after 8 REQ cycles, `timeout_err`=1, `done`=1, counts 0.
- `start` again from DONE: counts clear and traffic continues from the LFSR value, not `seed`.
